// File: rtl/idct_vecrot_seq.sv
// idct_vecrot_seq: frame sequencer for the IDCT vector-rotation stage.
// Ports: cfg_valid/cfg_ready/fftpts_in take a frame size N; rd_en and
//   rd_addr_a/rd_addr_b/coeff_addr drive the input buffer and the shared
//   2048-entry twiddle ROM; src_valid/src_sop/src_eop are the read strobe,
//   first point and last point, each delayed by LAT clocks to line up with
//   the read data; busy/done/cfg_err/frm_cnt report status; abort flushes
//   the block to IDLE.
// Latency: src_* trail rd_en by LAT clocks. done pulses LAT+1 clocks after the
//   last read. Backpressure: dn_ready=0 stalls the walk. The addresses hold
//   and no read is issued, so bubbles appear in the output stream.
module idct_vecrot_seq #(
    parameter int wAddr = 11,
    parameter int LAT   = 1,
    parameter int wFrm  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [11:0]      fftpts_in,
    input  logic             abort,
    input  logic             dn_ready,
    output logic             rd_en,
    output logic [wAddr-1:0] rd_addr_a,
    output logic [wAddr-1:0] rd_addr_b,
    output logic [wAddr-1:0] coeff_addr,
    output logic             src_valid,
    output logic             src_sop,
    output logic             src_eop,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [wFrm-1:0]  frm_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [wAddr-1:0] k;
    logic [wAddr:0]   n_reg;
    // step = 2048/N is a power of two, so only its log2 is kept.
    // coeff_addr is then a left shift of k.
    logic [2:0]       step_sh;
    logic [2:0]       drain_cnt;
    logic [LAT-1:0]   vld_sr;
    logic [LAT-1:0]   sop_sr;
    logic [LAT-1:0]   eop_sr;
    logic [wFrm-1:0]  frm_cnt_r;
    logic             cfg_err_r;

    logic             cfg_legal;
    logic [2:0]       cfg_sh;
    logic [wAddr-1:0] last_k;
    logic             k_is_first;
    logic             k_is_last;

    // Map each legal size to log2(2048/N). Any other value is rejected.
    always_comb begin
        cfg_legal = 1'b1;
        cfg_sh    = 3'd0;
        case (fftpts_in)
            12'd2048: cfg_sh = 3'd0;
            12'd1024: cfg_sh = 3'd1;
            12'd512:  cfg_sh = 3'd2;
            12'd256:  cfg_sh = 3'd3;
            12'd128:  cfg_sh = 3'd4;
            12'd64:   cfg_sh = 3'd5;
            12'd32:   cfg_sh = 3'd6;
            default:  cfg_legal = 1'b0;
        endcase
    end

    assign last_k     = wAddr'(n_reg - (wAddr+1)'(1));
    assign k_is_first = (k == '0);
    assign k_is_last  = (k == last_k);

    assign rd_en      = (state == S_RUN) && dn_ready;
    assign rd_addr_a  = k;
    // The mirror of k=0 is 0, not N. For N=2048, N itself would not fit
    // the address width anyway.
    assign rd_addr_b  = k_is_first ? '0 : wAddr'(n_reg - {1'b0, k});
    assign coeff_addr = k << step_sh;

    assign cfg_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    // abort in the final DRAIN clock overrides frame completion.
    assign done       = (state == S_DRAIN) && (drain_cnt == 3'd0) && !abort;
    assign cfg_err    = cfg_err_r;
    assign frm_cnt    = frm_cnt_r;
    assign src_valid  = vld_sr[LAT-1];
    assign src_sop    = sop_sr[LAT-1];
    assign src_eop    = eop_sr[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= '0;
            n_reg     <= '0;
            step_sh   <= 3'd0;
            drain_cnt <= 3'd0;
            vld_sr    <= '0;
            sop_sr    <= '0;
            eop_sr    <= '0;
            frm_cnt_r <= '0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= 1'b0;
            if (abort) begin
                // Flush: in-flight strobes are dropped and no frame is counted.
                state  <= S_IDLE;
                k      <= '0;
                vld_sr <= '0;
                sop_sr <= '0;
                eop_sr <= '0;
            end else begin
                vld_sr[0] <= rd_en;
                sop_sr[0] <= rd_en && k_is_first;
                eop_sr[0] <= rd_en && k_is_last;
                for (int i = 1; i < LAT; i++) begin
                    vld_sr[i] <= vld_sr[i-1];
                    sop_sr[i] <= sop_sr[i-1];
                    eop_sr[i] <= eop_sr[i-1];
                end
                case (state)
                    S_IDLE: begin
                        if (cfg_valid) begin
                            if (cfg_legal) begin
                                n_reg   <= (wAddr+1)'(fftpts_in);
                                step_sh <= cfg_sh;
                                k       <= '0;
                                state   <= S_RUN;
                            end else begin
                                cfg_err_r <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (rd_en) begin
                            if (k_is_last) begin
                                // k returns to 0 so the address outputs
                                // read 0 outside RUN.
                                k         <= '0;
                                drain_cnt <= 3'(LAT);
                                state     <= S_DRAIN;
                            end else begin
                                k <= k + wAddr'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == 3'd0) begin
                            frm_cnt_r <= frm_cnt_r + wFrm'(1);
                            state     <= S_IDLE;
                        end else begin
                            drain_cnt <= drain_cnt - 3'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_idct_vecrot_seq.sv
// tb_idct_vecrot_seq: directed bench for idct_vecrot_seq with LAT=1.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
module tb_idct_vecrot_seq;

    localparam int WA = 11;
    localparam int WF = 16;

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [11:0]   fftpts_in;
    logic          abort;
    logic          dn_ready;
    logic          rd_en;
    logic [WA-1:0] rd_addr_a;
    logic [WA-1:0] rd_addr_b;
    logic [WA-1:0] coeff_addr;
    logic          src_valid;
    logic          src_sop;
    logic          src_eop;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [WF-1:0] frm_cnt;

    int checks = 0;
    int errors = 0;

    idct_vecrot_seq #(.wAddr(WA), .LAT(1), .wFrm(WF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .fftpts_in  (fftpts_in),
        .abort      (abort),
        .dn_ready   (dn_ready),
        .rd_en      (rd_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .coeff_addr (coeff_addr),
        .src_valid  (src_valid),
        .src_sop    (src_sop),
        .src_eop    (src_eop),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .frm_cnt    (frm_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from its cfg clock (cycle 0) until done or a cycle budget.
    // A behavioural model tracks k and checks every cycle. Per-cycle
    // disagreements are accumulated in 'bad'.
    task automatic frame(input int n, input bit tog, input bit hold,
                         output int rd_cnt, output int vld_cnt,
                         output int sop_cnt, output int eop_cnt,
                         output int sop_cyc, output int eop_cyc,
                         output int done_cyc, output int bad);
        int  mk;
        int  step;
        int  last_rd;
        int  prev_k;
        bit  prev_rd;
        bit  exp_rd;
        bit  finished;
        step = 2048 / n;
        mk = 0; last_rd = -100; prev_k = 0; prev_rd = 1'b0;
        rd_cnt = 0; vld_cnt = 0; sop_cnt = 0; eop_cnt = 0;
        sop_cyc = -1; eop_cyc = -1; done_cyc = -1; bad = 0;
        cfg_valid = 1'b1;
        fftpts_in = 12'(n);
        dn_ready  = 1'b1;
        @(negedge clk);
        chk("cfg_ready_at_cfg", cfg_ready, 1);
        next_cyc();
        if (!hold) cfg_valid = 1'b0;
        finished = 1'b0;
        for (int cyc = 1; cyc < 4 * n + 20 && !finished; cyc++) begin
            dn_ready = tog ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            exp_rd = (mk < n) && dn_ready;
            if (rd_en !== exp_rd) bad++;
            if (mk < n) begin
                if (busy !== 1'b1) bad++;
                if (rd_addr_a !== WA'(mk)) bad++;
                if (rd_addr_b !== WA'((mk == 0) ? 0 : n - mk)) bad++;
                if (coeff_addr !== WA'(mk * step)) bad++;
            end
            if (src_valid !== prev_rd) bad++;
            if (src_sop !== (prev_rd && prev_k == 0)) bad++;
            if (src_eop !== (prev_rd && prev_k == n - 1)) bad++;
            if (done !== (cyc == last_rd + 2)) bad++;
            if (rd_en === 1'b1) rd_cnt++;
            if (src_valid === 1'b1) vld_cnt++;
            if (src_sop === 1'b1) begin sop_cnt++; sop_cyc = cyc; end
            if (src_eop === 1'b1) begin eop_cnt++; eop_cyc = cyc; end
            if (done === 1'b1) begin done_cyc = cyc; finished = 1'b1; end
            prev_rd = exp_rd;
            prev_k  = mk;
            if (exp_rd) begin
                if (mk == n - 1) last_rd = cyc;
                mk++;
            end
            next_cyc();
        end
        dn_ready = 1'b1;
    endtask

    int rd_c, vld_c, sop_c, eop_c, sop_y, eop_y, done_y, bad_c;
    int err_c, busy_c, done_c;
    bit found;

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; fftpts_in = '0; abort = 1'b0; dn_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_src_valid", src_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_frm_cnt", frm_cnt, 0);
        chk("rst_addr_b", rd_addr_b, 0);
        rst_n = 1'b1;
        next_cyc();

        // N=32 with no stalls
        frame(32, 1'b0, 1'b0, rd_c, vld_c, sop_c, eop_c, sop_y, eop_y, done_y, bad_c);
        chk("n32_bad", bad_c, 0);
        chk("n32_rd_cnt", rd_c, 32);
        chk("n32_vld_cnt", vld_c, 32);
        chk("n32_sop_cyc", sop_y, 2);
        chk("n32_eop_cyc", eop_y, 33);
        chk("n32_done_cyc", done_y, 34);
        chk("n32_frm_cnt", frm_cnt, 1);
        chk("n32_idle", busy, 0);

        // N=2048 with dn_ready toggling 1,0
        frame(2048, 1'b1, 1'b0, rd_c, vld_c, sop_c, eop_c, sop_y, eop_y, done_y, bad_c);
        chk("n2048_bad", bad_c, 0);
        chk("n2048_rd_cnt", rd_c, 2048);
        chk("n2048_vld_cnt", vld_c, 2048);
        chk("n2048_sop_cnt", sop_c, 1);
        chk("n2048_eop_cnt", eop_c, 1);
        chk("n2048_frm_cnt", frm_cnt, 2);

        // Illegal size 100, then a legal N=64
        cfg_valid = 1'b1; fftpts_in = 12'd100;
        @(negedge clk);
        chk("ill_err_same_clk", cfg_err, 0);
        next_cyc();
        cfg_valid = 1'b0;
        err_c = 0; busy_c = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("ill_err_next_clk", cfg_err, 1);
            if (cfg_err === 1'b1) err_c++;
            if (busy === 1'b1) busy_c++;
            next_cyc();
        end
        chk("ill_err_pulses", err_c, 1);
        chk("ill_busy", busy_c, 0);
        frame(64, 1'b0, 1'b0, rd_c, vld_c, sop_c, eop_c, sop_y, eop_y, done_y, bad_c);
        chk("n64_bad", bad_c, 0);
        chk("n64_rd_cnt", rd_c, 64);
        chk("n64_frm_cnt", frm_cnt, 3);

        // abort in IDLE beats cfg_valid
        cfg_valid = 1'b1; fftpts_in = 12'd64; abort = 1'b1;
        next_cyc();
        cfg_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", busy, 0);
        next_cyc();

        // N=256 aborted at k=100
        cfg_valid = 1'b1; fftpts_in = 12'd256; dn_ready = 1'b1;
        next_cyc();
        cfg_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (rd_addr_a === 11'd100 && busy === 1'b1) found = 1'b1;
            else next_cyc();
        end
        chk("abort_reach_k100", found, 1);
        abort = 1'b1;
        next_cyc();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_src_valid", src_valid, 0);
        chk("abort_cfg_ready", cfg_ready, 1);
        done_c = 0;
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            @(negedge clk);
            if (done === 1'b1) done_c++;
        end
        chk("abort_no_done", done_c, 0);
        chk("abort_frm_cnt", frm_cnt, 3);
        next_cyc();

        // Back-to-back N=512 then N=1024, cfg_valid held high
        frame(512, 1'b0, 1'b1, rd_c, vld_c, sop_c, eop_c, sop_y, eop_y, done_y, bad_c);
        chk("b2b512_bad", bad_c, 0);
        chk("b2b512_done_cyc", done_y, 514);
        chk("b2b512_frm_cnt", frm_cnt, 4);
        frame(1024, 1'b0, 1'b0, rd_c, vld_c, sop_c, eop_c, sop_y, eop_y, done_y, bad_c);
        chk("b2b1024_bad", bad_c, 0);
        chk("b2b1024_rd_cnt", rd_c, 1024);
        chk("b2b1024_frm_cnt", frm_cnt, 5);

        // Asynchronous reset in the middle of an N=128 frame
        cfg_valid = 1'b1; fftpts_in = 12'd128; dn_ready = 1'b1;
        next_cyc();
        cfg_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (rd_addr_a === 11'd60 && busy === 1'b1) found = 1'b1;
            else next_cyc();
        end
        chk("rst_reach_k60", found, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_addr_a", rd_addr_a, 0);
        chk("arst_coeff", coeff_addr, 0);
        chk("arst_src_valid", src_valid, 0);
        chk("arst_frm_cnt", frm_cnt, 0);
        chk("arst_cfg_ready", cfg_ready, 1);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
        frame(32, 1'b0, 1'b0, rd_c, vld_c, sop_c, eop_c, sop_y, eop_y, done_y, bad_c);
        chk("post_rst_bad", bad_c, 0);
        chk("post_rst_done_cyc", done_y, 34);
        chk("post_rst_frm_cnt", frm_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idct_vecrot_seq.md
Name: idct_vecrot_seq

Overview:
- Frame sequencer for the IDCT vector-rotation stage.
- Accepts one frame configuration (transform size N) and walks k = 0..N-1.
- Per point it issues: input-buffer read addresses for D1(k) and its mirror D1(N-k); the twiddle ROM address k*step into the shared 2048-entry cos/sin tables.
- A valid/sop/eop stream is delayed to align with the ROM/buffer read latency. This makes the block the only driver of the coefficient ROM address and the buffer read port.

Parameters:
- wAddr, 11, width of buffer and ROM addresses (supports N up to 2048)
- LAT, 1, read latency in clks of buffer and ROM; legal 1..4
- wFrm, 16, width of the frame counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- cfg_valid  in  1  frame request
- cfg_ready  out  1  high in IDLE only
- fftpts_in  in  12  N; legal 32, 64, 128, 256, 512, 1024, 2048
- abort  in  1  synchronous abort; flushes the block to IDLE
- dn_ready  in  1  downstream can accept a point this cycle
- rd_en  out  1  read strobe for buffer and ROM
- rd_addr_a  out  wAddr  address k
- rd_addr_b  out  wAddr  address (N-k) mod N
- coeff_addr  out  wAddr  k*step, where step = 2048/N
- src_valid  out  1  rd_en delayed LAT clks
- src_sop  out  1  marks k=0, aligned with src_valid
- src_eop  out  1  marks k=N-1, aligned with src_valid
- busy  out  1  state != IDLE
- done  out  1  1-clk pulse at the end of a frame
- cfg_err  out  1  1-clk pulse when an illegal size is rejected
- frm_cnt  out  wFrm  count of completed frames; wraps

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; k=0; N and step regs = 0; pipeline shift regs cleared.
  - All outputs 0 except cfg_ready=1.
  - Release is synchronous to clk.
- States are IDLE, RUN and DRAIN.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid with a legal fftpts_in: latch N, step = 2048/N (1,2,4,...,64), k=0; next state RUN.
  - On cfg_valid with an illegal fftpts_in: cfg_err pulses next clk; state stays IDLE; nothing is latched.
- RUN:
  - rd_en = dn_ready (combinational from the registered state).
  - rd_addr_a = k.
  - rd_addr_b = 0 when k=0, else N-k.
  - coeff_addr = k*step, implemented as a shift; it never exceeds 2047.
  - Addresses come from registers and hold their value while dn_ready=0. No read is issued during a stall; stalls insert bubbles in the output stream.
  - When rd_en=1 and k<N-1: k increments.
  - When rd_en=1 and k=N-1: next state DRAIN with a drain counter of LAT.
- DRAIN:
  - rd_en=0.
  - The counter decrements each clk. At 0: done pulses for one clk, frm_cnt increments, next state IDLE.
  - The first new cfg is accepted on the clk after done.
- Output alignment:
  - src_valid, src_sop (rd_en && k==0) and src_eop (rd_en && k==N-1) pass through an LAT-deep shift register.
  - First src_valid appears LAT clks after the first rd_en.
  - An unstalled frame gives N consecutive src_valid cycles.
- abort:
  - In RUN or DRAIN: next state IDLE, k=0, shift register cleared. Any in-flight src_valid is suppressed from the next clk.
  - No done, no frm_cnt increment.
  - In IDLE, abort has priority over cfg_valid: the cfg is not accepted.
- Other rules:
  - cfg_valid is ignored while busy; N and step cannot change mid-frame.
  - frm_cnt wraps from 2^wFrm-1 to 0.

Test Plan:
- N=32, dn_ready=1, LAT=1: cfg at clk 0 → rd_en clks 1..32. rd_addr_b sequence is 0,31,30,...,1. coeff_addr sequence is 0,64,128,...,1984. src_sop at clk 2, src_eop at clk 33, done at clk 34, frm_cnt=1.
- N=2048 with dn_ready toggling 1,0 → addresses hold during low cycles. Exactly 2048 rd_en pulses with coeff_addr=k. src_valid count = 2048, with sop and eop each seen exactly once.
- fftpts_in=100 → cfg_err single pulse, busy stays 0, next legal cfg (N=64, step 32) accepted normally.
- N=256, abort asserted at k=100 → next clk state IDLE, rd_en=0, src_valid=0 within 1 clk. No done; frm_cnt unchanged; cfg_ready=1.
- Back-to-back frames, N=512 then N=1024, cfg_valid held high → second frame starts the clk after done. step switches 4→2 and frm_cnt=2.
- rst_n pulled low mid-frame (N=128, k=60) → all outputs 0 immediately, without waiting for a clk edge, and cfg_ready=1. After release, a new N=32 frame runs correctly from k=0.
